// File: rtl/smu_cfg_loader_if.sv
// Configuration bus for the SMU config loader.
// Handshake: the serial bit stream is qualified per cycle by CfgValid. There is
// no ready or backpressure; the loader accepts every qualified bit in LOAD and
// PARITY. CfgStart (frame start) and CfgClear (disarm) are one-cycle commands,
// and CfgClear wins over everything else in the same cycle.
interface smu_cfg_loader_if #(
  parameter int N = 2,
  parameter int K = 4
);
  localparam int F = $clog2(N);

  // stream side, driven by the configuration master
  logic         CfgStart;
  logic         CfgValid;
  logic         CfgBit;
  logic         CfgClear;

  // committed configuration and status, driven by the loader
  logic [K-1:0] RegCmpMask;
  logic [K-1:0] RegCmp;
  logic [1:0]   RegCmpSelect;
  logic [F-1:0] RegFsmCmp;
  logic         SmuEn;
  logic         CfgBusy;
  logic         CfgDone;
  logic         CfgErr;

  modport master (
    output CfgStart, CfgValid, CfgBit, CfgClear,
    input  RegCmpMask, RegCmp, RegCmpSelect, RegFsmCmp,
    input  SmuEn, CfgBusy, CfgDone, CfgErr
  );

  modport slave (
    input  CfgStart, CfgValid, CfgBit, CfgClear,
    output RegCmpMask, RegCmp, RegCmpSelect, RegFsmCmp,
    output SmuEn, CfgBusy, CfgDone, CfgErr
  );
endinterface

// File: rtl/smu_cfg_loader.sv
// Serial configuration loader for one SMU. A frame is W = 2K+2+F payload bits,
// sent MSB-first as {mask, cmp, select, fsm_cmp}, followed by one even-parity
// bit. A good frame is committed to the Reg* outputs and arms the SMU; a bad
// frame sets a sticky error and leaves the previous configuration in place.
// N must be at least 2 so that the fsm-compare field has a nonzero width.
module smu_cfg_loader #(
  parameter int N = 2,
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                rst,
  smu_cfg_loader_if.slave     bus,
  output logic [2:0]          dbg_state
);

  localparam int F  = $clog2(N);
  localparam int W  = 2*K + 2 + F;
  localparam int CW = $clog2(W + 1);

  // field positions inside the shadow register
  localparam int FSM_LO  = 0;
  localparam int SEL_LO  = F;
  localparam int CMP_LO  = F + 2;
  localparam int MASK_LO = F + 2 + K;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PARITY = 3'd2,
    ARMED  = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [K-1:0]   mask_q, mask_d;
  logic [K-1:0]   cmp_q, cmp_d;
  logic [1:0]     sel_q, sel_d;
  logic [F-1:0]   fsm_q, fsm_d;
  logic           en_q, en_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           parity_ok;

  // even parity across the whole payload plus the incoming parity bit
  assign parity_ok = ~(^shadow_q ^ bus.CfgBit);

  // next-state and next-output logic; clear beats start beats the stream
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    cmp_d    = cmp_q;
    sel_d    = sel_q;
    fsm_d    = fsm_q;
    en_d     = en_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (bus.CfgClear) begin
      state_d = IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      cmp_d   = '0;
      sel_d   = '0;
      fsm_d   = '0;
      en_d    = 1'b0;
      err_d   = 1'b0;
    end else if (bus.CfgStart) begin
      // a start in any state (including mid-frame) begins a fresh frame;
      // a bit presented in the same cycle is not part of it
      state_d  = LOAD;
      cnt_d    = '0;
      shadow_d = '0;
      en_d     = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.CfgValid) begin
            shadow_d = {shadow_q[W-2:0], bus.CfgBit};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (bus.CfgValid) begin
            if (parity_ok) begin
              mask_d  = shadow_q[MASK_LO +: K];
              cmp_d   = shadow_q[CMP_LO +: K];
              sel_d   = shadow_q[SEL_LO +: 2];
              fsm_d   = shadow_q[FSM_LO +: F];
              en_d    = 1'b1;
              done_d  = 1'b1;
              state_d = ARMED;
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
        end
        default: begin
          // IDLE, ARMED and ERROR ignore the stream until the next start
        end
      endcase
    end
  end

  // state and registered outputs, asynchronously cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      cmp_q    <= '0;
      sel_q    <= '0;
      fsm_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      cmp_q    <= cmp_d;
      sel_q    <= sel_d;
      fsm_q    <= fsm_d;
      en_q     <= en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.RegCmpMask   = mask_q;
  assign bus.RegCmp       = cmp_q;
  assign bus.RegCmpSelect = sel_q;
  assign bus.RegFsmCmp    = fsm_q;
  assign bus.SmuEn        = en_q;
  assign bus.CfgDone      = done_q;
  assign bus.CfgErr       = err_q;
  assign bus.CfgBusy      = (state_q == LOAD) || (state_q == PARITY);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_smu_cfg_loader.sv
// Bench for smu_cfg_loader: directed frames followed by random traffic, every
// cycle compared against a frame-level reference model.
module tb_smu_cfg_loader;

  localparam int N = 2;
  localparam int K = 4;
  localparam int F = $clog2(N);
  localparam int W = 2*K + 2 + F;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_PARITY = 2;
  localparam int P_ARMED  = 3;
  localparam int P_ERROR  = 4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_pass;
  int         cyc;
  int         done_cyc;

  smu_cfg_loader_if #(.N(N), .K(K)) bus ();

  smu_cfg_loader #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks the frame as a list of received bits; the phase only records
  // whether a frame is in flight and how the last one ended.
  int         m_phase;
  logic       m_bits[$];
  logic [3:0] m_mask;
  logic [3:0] m_cmp;
  logic [1:0] m_sel;
  int         m_fsm;
  logic       m_en;
  logic       m_done;
  logic       m_err;

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_bits.delete();
    m_mask = '0; m_cmp = '0; m_sel = '0; m_fsm = 0;
    m_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic s, input logic v,
                                     input logic b, input logic c);
    int ones;
    int pay;
    m_done = 1'b0;
    if (c) begin
      model_reset();
    end else if (s) begin
      m_phase = P_LOAD;
      m_bits.delete();
      m_en  = 1'b0;
      m_err = 1'b0;
    end else if (m_phase == P_LOAD && v) begin
      m_bits.push_back(b);
      if (m_bits.size() == W + 1) begin
        ones = 0;
        pay  = 0;
        foreach (m_bits[i]) ones += int'(m_bits[i]);
        for (int i = 0; i < W; i++) pay = pay * 2 + int'(m_bits[i]);
        if (ones % 2 == 0) begin
          m_mask  = 4'((pay / (1 << (K + 2 + F))) % 16);
          m_cmp   = 4'((pay / (1 << (2 + F))) % 16);
          m_sel   = 2'((pay / (1 << F)) % 4);
          m_fsm   = pay % (1 << F);
          m_en    = 1'b1;
          m_done  = 1'b1;
          m_phase = P_ARMED;
        end else begin
          m_err   = 1'b1;
          m_phase = P_ERROR;
        end
        m_bits.delete();
      end
    end
  endfunction

  function automatic int model_state();
    if (m_phase == P_LOAD) return (m_bits.size() == W) ? P_PARITY : P_LOAD;
    return m_phase;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_all();
    check("mask",   int'(bus.RegCmpMask),   int'(m_mask));
    check("cmp",    int'(bus.RegCmp),       int'(m_cmp));
    check("sel",    int'(bus.RegCmpSelect), int'(m_sel));
    check("fsmcmp", int'(bus.RegFsmCmp),    m_fsm);
    check("en",     int'(bus.SmuEn),        int'(m_en));
    check("done",   int'(bus.CfgDone),      int'(m_done));
    check("err",    int'(bus.CfgErr),       int'(m_err));
    check("busy",   int'(bus.CfgBusy),      int'(m_phase == P_LOAD));
    check("state",  int'(dbg_state),        model_state());
    if (bus.SmuEn && bus.CfgBusy) check("en_while_busy", 1, 0);
  endtask

  // ---------------- drivers ----------------
  // one clock cycle: inputs applied away from the edge, outputs checked 1ns after
  task automatic cycle(input logic s, input logic v, input logic b, input logic c);
    bus.CfgStart = s; bus.CfgValid = v; bus.CfgBit = b; bus.CfgClear = c;
    @(posedge clk);
    cyc++;
    model_step(s, v, b, c);
    #1;
    if (bus.CfgDone) done_cyc = cyc;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  // payload MSB-first, optional stall of gap_len cycles after gap_after bits
  task automatic send_frame(input logic [W-1:0] p, input logic par,
                            input int gap_after, input int gap_len);
    cycle(1, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(0, 1, p[i], 0);
      if (W - i == gap_after) idle(gap_len);
    end
    cycle(0, 1, par, 0);
  endtask

  task automatic do_reset();
    bus.CfgStart = 0; bus.CfgValid = 0; bus.CfgBit = 0; bus.CfgClear = 0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  localparam logic [W-1:0] GOOD  = 11'b1111_1010_01_1;
  localparam logic [W-1:0] SECND = 11'b0000_0000_10_0;

  initial begin
    int t0;
    logic s, v, b, c;
    n_checks = 0; n_pass = 0; cyc = 0; done_cyc = -1;
    model_reset();
    do_reset();
    idle(2);

    // good frame and its commit latency
    t0 = cyc + 1;
    send_frame(GOOD, 1'b0, 0, 0);
    check("commit_latency", done_cyc - t0, W + 1);
    check("good_mask", int'(bus.RegCmpMask), 4'hF);
    check("good_sel",  int'(bus.RegCmpSelect), 2'b01);
    idle(3);

    // same frame with bad parity from a fresh reset
    do_reset();
    send_frame(GOOD, 1'b1, 0, 0);
    check("bad_err",   int'(bus.CfgErr), 1);
    check("bad_state", int'(dbg_state), P_ERROR);
    idle(2);

    // stalled frame: same commit, three cycles later
    done_cyc = -1;
    t0 = cyc + 1;
    send_frame(GOOD, 1'b0, 5, 3);
    check("stall_latency", done_cyc - t0, W + 1 + 3);
    check("stall_cmp", int'(bus.RegCmp), 4'hA);
    idle(2);

    // abort mid-frame while armed, then a second complete frame
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, GOOD[W-1-i], 0);
    cycle(1, 1, 1, 0);
    for (int i = W - 1; i >= 0; i--) cycle(0, 1, SECND[i], 0);
    cycle(0, 1, 1'b1, 0);
    check("restart_sel",  int'(bus.RegCmpSelect), 2'b10);
    check("restart_mask", int'(bus.RegCmpMask), 0);
    idle(2);

    // clear in the parity cycle of a good frame
    cycle(1, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) cycle(0, 1, GOOD[i], 0);
    cycle(0, 1, 1'b0, 1);
    check("clear_state", int'(dbg_state), P_IDLE);
    idle(2);

    // reset in the middle of a frame; trailing bits must not commit
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, GOOD[W-1-i], 0);
    do_reset();
    for (int i = 4; i < W; i++) cycle(0, 1, GOOD[W-1-i], 0);
    cycle(0, 1, 1'b0, 0);
    idle(2);

    // asynchronous reset while armed
    send_frame(GOOD, 1'b0, 0, 0);
    check("armed_en", int'(bus.SmuEn), 1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("async_en",   int'(bus.SmuEn), 0);
    check("async_mask", int'(bus.RegCmpMask), 0);
    check("async_cmp",  int'(bus.RegCmp), 0);
    check("async_sel",  int'(bus.RegCmpSelect), 0);
    check("async_fsm",  int'(bus.RegFsmCmp), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      cycle(s, v, b, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smu_cfg_loader.md
SMU_CFG_LOADER -- requirements
Module: smu_cfg_loader

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the maximum number of SMU pattern-match cycles; the FSM-compare field width SHALL be F = $clog2(N).
REQ-002 The block SHALL have parameter K, default 4, meaning the number of observable signal bits per SMU.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  is the asynchronous, active-low reset.
REQ-006 CfgStart  input  1  is a start-of-frame pulse.
REQ-007 CfgValid  input  1  qualifies CfgBit in the current cycle.
REQ-008 CfgBit  input  1  is the serial configuration data bit.
REQ-009 CfgClear  input  1  disarms the SMU and returns the block to IDLE.
REQ-010 RegCmpMask  output  K  is the committed comparator mask.
REQ-011 RegCmp  output  K  is the committed comparison value.
REQ-012 RegCmpSelect  output  2  is the committed comparison type: 00/11 eq, 01 lt, 10 gt.
REQ-013 RegFsmCmp  output  F  is the committed target match state.
REQ-014 SmuEn  output  1  enables the downstream SMU.
REQ-015 CfgBusy  output  1  is high while the block is in LOAD or PARITY.
REQ-016 CfgDone  output  1  is a one-cycle pulse on a successful commit.
REQ-017 CfgErr  output  1  is a sticky parity-error flag.

Function
REQ-018 The frame width SHALL be W = 2K+2+F payload bits followed by 1 parity bit.
REQ-019 The payload SHALL be shifted MSB-first as the concatenation {RegCmpMask, RegCmp, RegCmpSelect, RegFsmCmp}.
REQ-020 The FSM SHALL have states IDLE, LOAD, PARITY, ARMED and ERROR.
REQ-021 From IDLE, ARMED or ERROR, a CfgStart in a cycle SHALL move the FSM to LOAD, clear the bit counter, clear CfgErr and deassert SmuEn on the next edge.
REQ-022 In LOAD, each cycle with CfgValid high SHALL shift CfgBit into a W-bit shadow register and increment the bit counter; cycles with CfgValid low SHALL hold all state.
REQ-023 The bit counter SHALL be sized $clog2(W+1) bits and SHALL never wrap.
REQ-024 When the W-th payload bit is accepted, the FSM SHALL move to PARITY.
REQ-025 In PARITY, the first valid bit SHALL be taken as the parity bit; even parity SHALL hold over the W payload bits plus the parity bit.
REQ-026 On a parity match, on the next edge the outputs SHALL load from shadow, SmuEn SHALL go to 1, CfgDone SHALL pulse for exactly 1 cycle, and the FSM SHALL move to ARMED.
REQ-027 On a parity mismatch, on the next edge CfgErr SHALL go to 1, SmuEn SHALL stay 0, the outputs SHALL keep their previous values, and the FSM SHALL move to ERROR.
REQ-028 The Reg* outputs SHALL change only on a commit, on reset, or on CfgClear.
REQ-029 SmuEn SHALL never be high while CfgBusy is high.
REQ-030 A CfgStart during LOAD or PARITY SHALL abort the frame and restart LOAD with the counter at 0; CfgValid/CfgBit in that same cycle SHALL be ignored.
REQ-031 CfgClear SHALL take priority over CfgStart, CfgValid and the commit: on the next edge SmuEn=0, CfgErr=0, FSM=IDLE, and the Reg* outputs SHALL be 0.
REQ-032 In IDLE, ARMED and ERROR, CfgValid without CfgStart SHALL be ignored.
REQ-033 CfgBusy SHALL be combinational from the state; all other outputs SHALL be registered.

Reset
REQ-034 On rst low, asynchronously: FSM=IDLE, counter=0, shadow=0, all Reg* outputs=0, SmuEn=0, CfgDone=0, CfgErr=0.
REQ-035 Deassertion of rst SHALL take effect at the first rising clk edge with rst high.
REQ-036 A reset asserted mid-LOAD SHALL discard the partial frame, and no commit SHALL follow.

Verification (N=2, K=4, W=11)
REQ-037 Reset, then CfgStart, then bits 1111_1010_01_1 and parity 0 -> CfgDone pulses once, RegCmpMask=4'hF, RegCmp=4'hA, RegCmpSelect=2'b01, RegFsmCmp=1, SmuEn=1.
REQ-038 The same frame with parity 1 -> CfgErr=1, SmuEn=0, all Reg* outputs remain 0, FSM=ERROR.
REQ-039 A valid frame with CfgValid low for 3 cycles after bit 5 -> the commit values are identical to REQ-037 and the commit is delayed by 3 cycles.
REQ-040 While ARMED, CfgStart followed by 6 bits then a second CfgStart and a full frame 0000_0000_10_0 with parity 1 -> SmuEn=0 from the first CfgStart until commit, final RegCmpSelect=2'b10 and RegCmpMask=0.
REQ-041 CfgClear asserted in the same cycle as the parity bit of a good frame -> no CfgDone, SmuEn=0, FSM=IDLE.
REQ-042 rst pulsed low asynchronously between clock edges while ARMED -> SmuEn and all Reg* outputs go to 0 immediately, without waiting for a clock edge.
